// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage registers: state encodings,
// the bubble control value and per-stage control bundle widths.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  // All-zero control is the NOP; sized wide so any stage can cast it down.
  localparam logic [63:0] CTRL_NOP = 64'd0;

  localparam int CTRL_W_IDEX  = 12;
  localparam int CTRL_W_EXMEM = 8;

endpackage

// File: rtl/pipe_slot.sv
// One storage entry (valid + ctrl + data) of the skid pipeline stage.
// kill turns the entry into a bubble but keeps the payload; drop only invalidates it.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              kill,
  input  logic              drop,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              q_valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q_valid <= 1'b0;
      q_ctrl  <= CTRL_W'(CTRL_NOP);
      q_data  <= '0;
    end else if (kill) begin
      q_valid <= 1'b0;
      q_ctrl  <= CTRL_W'(CTRL_NOP);
    end else if (load) begin
      q_valid <= 1'b1;
      q_ctrl  <= d_ctrl;
      q_data  <= d_data;
    end else if (drop) begin
      q_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with a 2-entry skid buffer and flush-to-bubble.
// Optional PIPE_PERF_CNT_EN adds saturating stall and flush counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  perf_stall_cnt,
  output logic [CNT_W-1:0]  perf_flush_cnt
`endif
);

  logic [1:0]        state, state_n;
  logic              in_hs, out_hs;
  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              main_load, main_drop, skid_load, skid_drop;
  logic [CTRL_W-1:0] main_d_ctrl;
  logic [DATA_W-1:0] main_d_data;

  // Slot valids mirror the state register, so they drive the handshake directly.
  assign out_valid = main_valid;
  assign in_ready  = !flush && !skid_valid;
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign out_ctrl  = main_valid ? main_ctrl : CTRL_W'(CTRL_NOP);

  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (in_hs) state_n = ST_ONE;
        ST_ONE: begin
          if (in_hs && !out_hs)      state_n = ST_TWO;
          else if (out_hs && !in_hs) state_n = ST_EMPTY;
        end
        ST_TWO:   if (out_hs) state_n = ST_ONE;
        default:  state_n = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_n;
  end

  // Main refills from the skid entry when draining TWO, otherwise from the input.
  assign main_load   = (state == ST_EMPTY && in_hs) ||
                       (state == ST_ONE && in_hs && out_hs) ||
                       (state == ST_TWO && out_hs);
  assign main_drop   = (state == ST_ONE) && out_hs && !in_hs;
  assign main_d_ctrl = (state == ST_TWO) ? skid_ctrl : in_ctrl;
  assign main_d_data = (state == ST_TWO) ? skid_data : in_data;
  assign skid_load   = (state == ST_ONE) && in_hs && !out_hs;
  assign skid_drop   = (state == ST_TWO) && out_hs;

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk     (clk),
    .reset   (reset),
    .load    (main_load),
    .kill    (flush),
    .drop    (main_drop),
    .d_ctrl  (main_d_ctrl),
    .d_data  (main_d_data),
    .q_valid (main_valid),
    .q_ctrl  (main_ctrl),
    .q_data  (out_data)
  );

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .load    (skid_load),
    .kill    (flush),
    .drop    (skid_drop),
    .d_ctrl  (in_ctrl),
    .d_data  (in_data),
    .q_valid (skid_valid),
    .q_ctrl  (skid_ctrl),
    .q_data  (skid_data)
  );

`ifdef PIPE_PERF_CNT_EN
  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      if (flush && out_valid && perf_flush_cnt != '1)
        perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid; also covers the counters when PIPE_PERF_CNT_EN is defined.
module tb_pipe_stage_skid;

  localparam int DATA_W = 128;
  localparam int CTRL_W = 12;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_data, out_data;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0]  perf_stall_cnt, perf_flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data)
`ifdef PIPE_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  function automatic logic [DATA_W-1:0] mk_data(input logic [CTRL_W-1:0] c);
    return {8'hA5, {10{c}}};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic fl, input logic iv,
                               input logic [CTRL_W-1:0] c, input logic ordy);
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = mk_data(c);
    out_ready = ordy;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(1, 0, 0, '0, 0);
    tick;
    tick;
    applyStimulus(0, 0, 0, '0, 1);
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_ctrl", out_ctrl, 0);
    checkOutput("rst_data", out_data, 0);
    checkOutput("rst_in_ready", in_ready, 1);

    // Full-rate stream of 0x001..0x008
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 0, 1, CTRL_W'(i), 1);
      checkOutput("stream_in_ready", in_ready, 1);
      tick;
      checkOutput("stream_valid", out_valid, 1);
      checkOutput("stream_ctrl", out_ctrl, 128'(i));
      checkOutput("stream_data", out_data, mk_data(CTRL_W'(i)));
    end
    applyStimulus(0, 0, 0, '0, 1);
    tick;
    checkOutput("stream_drain_valid", out_valid, 0);
    checkOutput("stream_drain_ctrl", out_ctrl, 0);

    // Backpressure with A then B held, extra input refused
    applyStimulus(0, 0, 1, 12'h0A1, 0);
    tick;
    applyStimulus(0, 0, 1, 12'h0B2, 0);
    checkOutput("bp_accept_b", in_ready, 1);
    tick;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 1, 12'h0C3, 0);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_valid", out_valid, 1);
      checkOutput("bp_ctrl", out_ctrl, 12'h0A1);
      checkOutput("bp_data", out_data, mk_data(12'h0A1));
      tick;
    end
    applyStimulus(0, 0, 0, '0, 1);
    checkOutput("bp_out_a", out_ctrl, 12'h0A1);
    tick;
    checkOutput("bp_out_b", out_ctrl, 12'h0B2);
    checkOutput("bp_out_b_data", out_data, mk_data(12'h0B2));
    checkOutput("bp_in_ready_one", in_ready, 1);
    tick;
    checkOutput("bp_empty", out_valid, 0);

    // Flush while TWO, with a concurrent input that must be dropped
    applyStimulus(0, 0, 1, 12'h0D4, 0);
    tick;
    applyStimulus(0, 0, 1, 12'h0E5, 0);
    tick;
    applyStimulus(0, 1, 1, 12'h0F6, 1);
    checkOutput("flush_in_ready", in_ready, 0);
    tick;
    applyStimulus(0, 0, 0, '0, 1);
    checkOutput("flush_valid", out_valid, 0);
    checkOutput("flush_ctrl", out_ctrl, 0);
    checkOutput("flush_in_ready_after", in_ready, 1);
    tick;
    checkOutput("flush_no_ghost", out_valid, 0);

    // Simultaneous in/out while ONE
    applyStimulus(0, 0, 1, 12'h101, 0);
    tick;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 0, 1, CTRL_W'(12'h102 + k), 1);
      checkOutput("sim_in_ready", in_ready, 1);
      checkOutput("sim_ctrl", out_ctrl, 128'(12'h101 + k));
      tick;
    end
    applyStimulus(0, 0, 0, '0, 1);
    checkOutput("sim_last", out_ctrl, 12'h10B);
    tick;
    checkOutput("sim_empty", out_valid, 0);

    // Reset in TWO with flush and input asserted
    applyStimulus(0, 0, 1, 12'h201, 0);
    tick;
    applyStimulus(0, 0, 1, 12'h202, 0);
    tick;
    applyStimulus(1, 1, 1, 12'h203, 1);
    tick;
    applyStimulus(0, 0, 0, '0, 1);
    checkOutput("midrst_valid", out_valid, 0);
    checkOutput("midrst_ctrl", out_ctrl, 0);
    checkOutput("midrst_data", out_data, 0);
    checkOutput("midrst_in_ready", in_ready, 1);

`ifdef PIPE_PERF_CNT_EN
    checkOutput("perf_stall_rst", perf_stall_cnt, 0);
    checkOutput("perf_flush_rst", perf_flush_cnt, 0);
    applyStimulus(0, 0, 1, 12'h301, 0);
    tick;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(0, 0, 0, '0, 0);
      tick;
    end
    checkOutput("perf_stall_sat", perf_stall_cnt, 15);
    checkOutput("perf_flush_zero", perf_flush_cnt, 0);
    applyStimulus(0, 1, 0, '0, 0);
    tick;
    checkOutput("perf_flush_one", perf_flush_cnt, 1);
    applyStimulus(0, 1, 0, '0, 0);
    tick;
    checkOutput("perf_flush_empty", perf_flush_cnt, 1);
    applyStimulus(0, 0, 0, '0, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
